alu_secuencial: RTL
===================

// Module: alu_secuencial
// PURPOSE
//  Parametrised, registered successor to the combinational ALU. Executes the same op set
//  (add/sub/inc/dec/logic) plus multi-bit shifts and rotates, using a valid/ready handshake
//  on both sides. Shift and rotate ops iterate one bit per cycle.
//  Sits between the operand register file and the result/flag writeback stage.
// PARAMETERS
//  N    8           data width; legal for N >= 2
//  SHW  $clog2(N)   shift-amount width; the amount is taken from B[SHW-1:0]
// PORTS
//  clk         in   1    single clock; all state updates on the rising edge
//  rst_n       in   1    asynchronous, active-low reset
//  in_valid    in   1    operand/op valid
//  in_ready    out  1    block can accept an op this cycle
//  A           in   N    operand A
//  B           in   N    operand B, or shift amount for ops 8-11
//  flagin      in   1    ops 2/3/6: 1 selects A, 0 selects B; ops 8/9: fill bit
//  select      in   4    opcode
//  out_valid   out  1    result/flags valid
//  out_ready   in   1    consumer accepts the result
//  resultado   out  N    result
//  opnegativo  out  1    result[N-1]
//  ozero       out  1    result == 0
//  ocout       out  1    carry / bit shifted out
//  ooverflow   out  1    signed two's-complement overflow
//  oilegal     out  1    opcode 12-15 was issued
// BEHAVIOUR
//  Opcodes:
//   0 ADD  A+B
//   1 SUB  A+~B+1
//   2 INC  X+1
//   3 DEC  X-1, where X = flagin ? A : B (ops 2 and 3)
//   4 AND
//   5 OR
//   6 NOT  flagin ? ~A : ~B
//   7 XOR
//   8 SHL  fill=flagin
//   9 SHR  logical, fill=flagin
//   10 ROL
//   11 ROR
//   12-15 illegal
//  Flags:
//   - ops 0-3: ocout = adder carry-out (SUB: 1 means no borrow); ooverflow = signed overflow.
//   - ops 4-7: ocout = 0, ooverflow = 0.
//   - ops 8-11: ocout = last bit shifted/rotated out (0 if amount = 0); ooverflow = 0.
//   - opnegativo and ozero are computed from the final result for every legal op.
//   - Illegal op: resultado = 0, all four flags = 0, oilegal = 1. oilegal = 0 for legal ops.
//  FSM states:
//   - IDLE: in_ready = 1. On in_valid, register A, B, select and flagin.
//     Ops 0-7 and illegal ops go to DONE. Ops 8-11 load cnt = B[SHW-1:0] and go to EXEC.
//   - EXEC: while cnt != 0, shift/rotate the working register by 1 and decrement cnt.
//     When cnt == 0, go to DONE.
//   - DONE: out_valid = 1; outputs held stable until out_ready. On out_ready, go to IDLE.
//     If in_valid is also high that cycle (in_ready = out_ready in DONE), accept the new op
//     directly, with the same routing as IDLE.
//  Latency (accept edge to out_valid):
//   - ops 0-7 and illegal: 1 cycle.
//   - ops 8-11: s+2 cycles, where s = B[SHW-1:0]; s = 0 gives 2 cycles, result = A, ocout = 0.
//  Shift amounts:
//   - s >= N (possible for N not a power of 2): SHL/SHR yield all-fill; rotates wrap naturally.
//  Handshake:
//   - Inputs are ignored unless in_valid && in_ready.
//   - in_valid during EXEC is ignored; the source must hold it.
//  Reset:
//   - IDLE, out_valid = 0, resultado = 0, all flags = 0, oilegal = 0, cnt = 0; in_ready = 1.
//   - Applies immediately, including mid-EXEC. No stale result appears after release.
// STRUCTURE
//  - Package alu_pkg: opcode localparams OP_ADD..OP_ROR; state encoding IDLE/EXEC/DONE.
//  - Sub-module alu_nucleo #(N): combinational ops 0-7 producing result, cout and overflow.
//  - Top level holds the FSM, operand registers, shift iterator, flag generation and
//    output registers.
// TESTING (N=8)
//  1. ADD A=8'h7F B=8'h01 -> 1 cycle later: resultado=8'h80, ooverflow=1, ocout=0,
//     opnegativo=1, ozero=0.
//  2. SUB A=8'h05 B=8'h05 -> resultado=8'h00, ozero=1, ocout=1, ooverflow=0;
//     DEC flagin=1 A=8'h00 -> 8'hFF, ocout=0, opnegativo=1.
//  3. SHL A=8'h81 B=3 flagin=0 -> out_valid 5 cycles after accept, resultado=8'h08, ocout=0;
//     ROR A=8'h01 B=1 -> 8'h80, ocout=1, opnegativo=1.
//  4. out_ready=0 for 5 cycles after result -> resultado/flags stable, in_ready=0, extra
//     in_valid ignored; then out_ready=1 with in_valid=1 same cycle -> new op accepted,
//     its result 1 cycle later.
//  5. rst_n=0 during EXEC of SHR B=7 -> outputs 0 immediately; after release in_ready=1,
//     out_valid stays 0.
//  6. select=13 -> resultado=0, oilegal=1, all flags 0; next legal op -> oilegal=0.

Source files
------------

// File: rtl/alu_secuencial_pkg.sv
// Shared definitions for the sequential ALU.
// Contents: opcode constants OP_ADD..OP_ROR, FSM state encoding, and
// opcode classification helpers used by the top level.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ops 8-11 iterate one bit per cycle.
    function automatic logic is_shift(input logic [3:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

    // Opcodes 12-15 are not defined.
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/alu_secuencial_if.sv
// Operand/result handshake bundle for alu_secuencial.
// Input side : in_valid/in_ready, A, B, flagin, select.
// Output side: out_valid/out_ready, resultado and flags
//              (opnegativo, ozero, ocout, ooverflow, oilegal).
// Modports: slave = the ALU, master = operand source / result consumer.
interface alu_secuencial_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         flagin;
    logic [3:0]   select;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] resultado;
    logic         opnegativo;
    logic         ozero;
    logic         ocout;
    logic         ooverflow;
    logic         oilegal;

    modport slave (
        input  in_valid, A, B, flagin, select, out_ready,
        output in_ready, out_valid, resultado,
               opnegativo, ozero, ocout, ooverflow, oilegal
    );

    modport master (
        output in_valid, A, B, flagin, select, out_ready,
        input  in_ready, out_valid, resultado,
               opnegativo, ozero, ocout, ooverflow, oilegal
    );
endinterface

// File: rtl/alu_secuencial_nucleo.sv
// Combinational core for ops 0-7 (add/sub/inc/dec and logic).
// Ports: a, b (operands), flagin (operand select for INC/DEC/NOT),
//        op (opcode), result, cout (adder carry-out), ovf (signed overflow).
// Any other opcode yields result = 0, cout = 0, ovf = 0.
module alu_nucleo
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flagin,
    input  logic [3:0]   op,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         ovf
);

    logic [N-1:0] x;
    logic [N-1:0] add_p;
    logic [N-1:0] add_q;
    logic         add_cin;
    logic [N:0]   sum;

    // All four arithmetic ops share one adder: SUB is A+~B+1, INC is X+0+1,
    // DEC is X+all-ones, so carry and overflow come out of the same equations.
    always_comb begin
        x       = flagin ? a : b;
        add_p   = a;
        add_q   = b;
        add_cin = 1'b0;
        case (op)
            OP_SUB: begin
                add_q   = ~b;
                add_cin = 1'b1;
            end
            OP_INC: begin
                add_p   = x;
                add_q   = '0;
                add_cin = 1'b1;
            end
            OP_DEC: begin
                add_p   = x;
                add_q   = '1;
            end
            default: ;
        endcase
        sum = {1'b0, add_p} + {1'b0, add_q} + {{N{1'b0}}, add_cin};
    end

    always_comb begin
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                result = sum[N-1:0];
                cout   = sum[N];
                ovf    = (add_p[N-1] == add_q[N-1]) && (sum[N-1] != add_p[N-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_NOT: result = flagin ? ~a : ~b;
            OP_XOR: result = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_secuencial.sv
// Registered ALU with valid/ready handshake on both sides.
// Ports: clk, rst_n (async active-low), bus (alu_secuencial_if.slave).
// Ops 0-7 and illegal ops complete in one cycle; shifts/rotates (8-11)
// iterate one bit per cycle over B[SHW-1:0] positions.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for an op; ops 0-7/illegal -> DONE, ops 8-11 -> EXEC
// EXEC  | shift/rotate working register one bit per cycle until cnt=0
// DONE  | result held with out_valid=1 until out_ready; can accept the
//       | next op in the same cycle the result is taken
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int N   = 8,
    parameter int SHW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_secuencial_if.slave    bus
);

    state_t         state;
    state_t         state_n;
    logic           accept;
    logic           step;
    logic           finish;
    logic           in_ready_c;
    logic           in_shift;
    logic           in_illegal;

    logic [N-1:0]   work;
    logic [N-1:0]   work_n;
    logic           work_out;
    logic [SHW-1:0] cnt;
    logic [3:0]     op_q;
    logic           fill_q;
    logic           sh_cout;

    logic [N-1:0]   core_res;
    logic           core_cout;
    logic           core_ovf;

    logic [N-1:0]   res_q;
    logic           neg_q;
    logic           zero_q;
    logic           cout_q;
    logic           ovf_q;
    logic           ileg_q;

    alu_nucleo #(.N(N)) u_nucleo (
        .a      (bus.A),
        .b      (bus.B),
        .flagin (bus.flagin),
        .op     (bus.select),
        .result (core_res),
        .cout   (core_cout),
        .ovf    (core_ovf)
    );

    assign in_shift   = is_shift(bus.select);
    assign in_illegal = is_illegal(bus.select);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_n = in_shift ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (cnt != '0) begin
                    step = 1'b1;
                end else begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                // The slot frees up exactly when the consumer takes the result.
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        state_n = in_shift ? EXEC : DONE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        work_n   = work;
        work_out = 1'b0;
        case (op_q)
            OP_SHL: begin
                work_n   = {work[N-2:0], fill_q};
                work_out = work[N-1];
            end
            OP_SHR: begin
                work_n   = {fill_q, work[N-1:1]};
                work_out = work[0];
            end
            OP_ROL: begin
                work_n   = {work[N-2:0], work[N-1]};
                work_out = work[N-1];
            end
            OP_ROR: begin
                work_n   = {work[0], work[N-1:1]};
                work_out = work[0];
            end
            default: ;
        endcase
    end

    // sh_cout restarts at 0 so an amount of zero reports no bit shifted out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            cnt     <= '0;
            op_q    <= OP_ADD;
            fill_q  <= 1'b0;
            sh_cout <= 1'b0;
        end else if (accept) begin
            work    <= bus.A;
            cnt     <= in_shift ? bus.B[SHW-1:0] : '0;
            op_q    <= bus.select;
            fill_q  <= bus.flagin;
            sh_cout <= 1'b0;
        end else if (step) begin
            work    <= work_n;
            sh_cout <= work_out;
            cnt     <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            ileg_q <= 1'b0;
        end else if (accept && !in_shift) begin
            if (in_illegal) begin
                res_q  <= '0;
                neg_q  <= 1'b0;
                zero_q <= 1'b0;
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
                ileg_q <= 1'b1;
            end else begin
                res_q  <= core_res;
                neg_q  <= core_res[N-1];
                zero_q <= (core_res == '0);
                cout_q <= core_cout;
                ovf_q  <= core_ovf;
                ileg_q <= 1'b0;
            end
        end else if (finish) begin
            res_q  <= work;
            neg_q  <= work[N-1];
            zero_q <= (work == '0);
            cout_q <= sh_cout;
            ovf_q  <= 1'b0;
            ileg_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = (state == DONE);
    assign bus.resultado  = res_q;
    assign bus.opnegativo = neg_q;
    assign bus.ozero      = zero_q;
    assign bus.ocout      = cout_q;
    assign bus.ooverflow  = ovf_q;
    assign bus.oilegal    = ileg_q;

endmodule
